rom_sdram_bridge: RTL and testbench

// - Sits directly downstream of the cartridge mapper mux. Consumes the ROM_* strobe bus (ROM_ADDR/D/CE_N/OE_N/WE_N/WORD).
// - Converts each new access into a single req/ack transaction toward the SDRAM controller.
// - Returns ROM_Q to the mapper and keeps a one-word read cache, so repeated fetches of the same word do not touch SDRAM.

---
 rtl/snes_mem_pkg.sv | 21 ++
 rtl/rom_sdram_bridge_if.sv | 31 +++
 rtl/rom_word_cache.sv | 49 ++++
 rtl/rom_sdram_bridge.sv | 145 ++++++++++++++
 tb/tb_rom_sdram_bridge.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snes_mem_pkg.sv
// Shared definitions for the cartridge ROM / SDRAM path.
// Holds FSM encodings, byte-enable constants and the ROM_Q formatter.
package snes_mem_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RD_REQ = 2'd1;
    localparam logic [1:0] ST_WR_REQ = 2'd2;

    localparam logic [1:0] BE_LO = 2'b01;
    localparam logic [1:0] BE_HI = 2'b10;
    localparam logic [1:0] BE_W  = 2'b11;

    // Byte reads return the selected lane duplicated into both halves.
    function automatic logic [15:0] fmt_q(input logic [15:0] word16, input logic word,
                                          input logic a0);
        logic [7:0] b;
        b = a0 ? word16[15:8] : word16[7:0];
        return word ? word16 : {b, b};
    endfunction

endpackage

// File: rtl/rom_sdram_bridge_if.sv
// ROM strobe bus from the mapper plus the req/ack channel to the SDRAM controller.
// The bridge takes the slave view; whoever drives the ROM bus and acks takes master.
interface rom_sdram_bridge_if #(
    parameter int unsigned ADDR_W = 24
) ();
    logic [ADDR_W-1:0] ROM_ADDR;
    logic [15:0]       ROM_D;
    logic              ROM_CE_N;
    logic              ROM_OE_N;
    logic              ROM_WE_N;
    logic              ROM_WORD;
    logic [15:0]       ROM_Q;
    logic              BUSY;
    logic              SD_REQ;
    logic              SD_WE;
    logic [ADDR_W-1:0] SD_ADDR;
    logic [1:0]        SD_BE;
    logic [15:0]       SD_WDATA;
    logic              SD_ACK;
    logic [15:0]       SD_RDATA;

    modport slave (
        input  ROM_ADDR, ROM_D, ROM_CE_N, ROM_OE_N, ROM_WE_N, ROM_WORD, SD_ACK, SD_RDATA,
        output ROM_Q, BUSY, SD_REQ, SD_WE, SD_ADDR, SD_BE, SD_WDATA
    );

    modport master (
        output ROM_ADDR, ROM_D, ROM_CE_N, ROM_OE_N, ROM_WE_N, ROM_WORD, SD_ACK, SD_RDATA,
        input  ROM_Q, BUSY, SD_REQ, SD_WE, SD_ADDR, SD_BE, SD_WDATA
    );
endinterface

// File: rtl/rom_word_cache.sv
// One-word read cache: tag, valid and 16-bit data with byte-masked write-through.
// A masked write landing alongside a fill overrides the fill data.
module rom_word_cache #(
    parameter int unsigned TAG_W = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TAG_W-1:0] i_lk_tag,
    input  logic             i_wr_en,
    input  logic [1:0]       i_wr_be,
    input  logic [15:0]      i_wr_data,
    input  logic             i_fill_en,
    input  logic [TAG_W-1:0] i_fill_tag,
    input  logic [15:0]      i_fill_data,
    output logic             o_hit,
    output logic [15:0]      o_data
);
    logic             r_valid;
    logic [TAG_W-1:0] r_tag;
    logic [15:0]      r_data;
    logic             w_valid;
    logic [TAG_W-1:0] w_tag;
    logic [15:0]      w_data;
    logic             w_wr_hit;

    always_comb begin
        w_valid  = r_valid | i_fill_en;
        w_tag    = i_fill_en ? i_fill_tag : r_tag;
        w_data   = i_fill_en ? i_fill_data : r_data;
        w_wr_hit = i_wr_en & w_valid & (w_tag == i_lk_tag);
        if (w_wr_hit & i_wr_be[0]) w_data[7:0]  = i_wr_data[7:0];
        if (w_wr_hit & i_wr_be[1]) w_data[15:8] = i_wr_data[15:8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= w_valid;
            r_tag   <= w_tag;
            r_data  <= w_data;
        end
    end

    assign o_hit  = r_valid & (r_tag == i_lk_tag);
    assign o_data = r_data;
endmodule

// File: rtl/rom_sdram_bridge.sv
// Turns mapper ROM strobes into single SDRAM req/ack transactions, with a
// depth-1 pending slot for accesses that arrive while a transaction is in flight.
module rom_sdram_bridge
    import snes_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 24,
    parameter logic        USE_CACHE = 1'b1
) (
    input  logic              MCLK,
    input  logic              RESET,
    rom_sdram_bridge_if.slave bus
);
    logic              w_act, w_wr, w_new;
    logic              r_act, r_word, r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_pend, r_p_word, r_p_wr;
    logic [ADDR_W-1:0] r_p_addr;
    logic [15:0]       r_p_d;
    logic [1:0]        r_state;
    logic              r_cur_word, r_cur_a0;
    logic [15:0]       r_rom_q;
    logic              r_sd_req, r_sd_we;
    logic [ADDR_W-1:0] r_sd_addr;
    logic [1:0]        r_sd_be;
    logic [15:0]       r_sd_wdata;
    logic              w_sel_vld, w_sel_word, w_sel_wr;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [15:0]       w_sel_d, w_sel_wdata;
    logic [1:0]        w_sel_be;
    logic              w_hit, w_fill;
    logic [15:0]       w_cdata;

    assign w_act = ~bus.ROM_CE_N & (~bus.ROM_OE_N | ~bus.ROM_WE_N);
    assign w_wr  = ~bus.ROM_WE_N;
    assign w_new = w_act & (~r_act | (bus.ROM_ADDR != r_addr) | (bus.ROM_WORD != r_word) |
                            (w_wr != r_wr));

    // A fresh access in IDLE supersedes whatever is still pending.
    always_comb begin
        w_sel_vld   = (r_state == ST_IDLE) & (w_new | r_pend);
        w_sel_addr  = w_new ? bus.ROM_ADDR : r_p_addr;
        w_sel_d     = w_new ? bus.ROM_D    : r_p_d;
        w_sel_word  = w_new ? bus.ROM_WORD : r_p_word;
        w_sel_wr    = w_new ? w_wr         : r_p_wr;
        w_sel_be    = w_sel_word ? BE_W : (w_sel_addr[0] ? BE_HI : BE_LO);
        w_sel_wdata = w_sel_word ? w_sel_d : {w_sel_d[7:0], w_sel_d[7:0]};
    end

    assign w_fill = (r_state == ST_RD_REQ) & bus.SD_ACK;

    generate
        if (USE_CACHE) begin : g_cache
            rom_word_cache #(
                .TAG_W(ADDR_W - 1)
            ) u_cache (
                .clk        (MCLK),
                .rst        (RESET),
                .i_lk_tag   (w_sel_addr[ADDR_W-1:1]),
                .i_wr_en    (w_sel_vld & w_sel_wr),
                .i_wr_be    (w_sel_be),
                .i_wr_data  (w_sel_wdata),
                .i_fill_en  (w_fill),
                .i_fill_tag (r_sd_addr[ADDR_W-1:1]),
                .i_fill_data(bus.SD_RDATA),
                .o_hit      (w_hit),
                .o_data     (w_cdata)
            );
        end else begin : g_no_cache
            assign w_hit   = 1'b0;
            assign w_cdata = '0;
        end
    endgenerate

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            r_act      <= 1'b0;
            r_word     <= 1'b0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_pend     <= 1'b0;
            r_p_word   <= 1'b0;
            r_p_wr     <= 1'b0;
            r_p_addr   <= '0;
            r_p_d      <= '0;
            r_state    <= ST_IDLE;
            r_cur_word <= 1'b0;
            r_cur_a0   <= 1'b0;
            r_rom_q    <= '0;
            r_sd_req   <= 1'b0;
            r_sd_we    <= 1'b0;
            r_sd_addr  <= '0;
            r_sd_be    <= '0;
            r_sd_wdata <= '0;
        end else begin
            r_act  <= w_act;
            r_addr <= bus.ROM_ADDR;
            r_word <= bus.ROM_WORD;
            r_wr   <= w_wr;
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_vld) begin
                        r_pend <= 1'b0;
                        if (w_sel_wr || !w_hit) begin
                            r_state    <= w_sel_wr ? ST_WR_REQ : ST_RD_REQ;
                            r_sd_req   <= 1'b1;
                            r_sd_we    <= w_sel_wr;
                            r_sd_addr  <= {w_sel_addr[ADDR_W-1:1], 1'b0};
                            r_sd_be    <= w_sel_be;
                            r_sd_wdata <= w_sel_wdata;
                            r_cur_word <= w_sel_word;
                            r_cur_a0   <= w_sel_addr[0];
                        end else begin
                            r_rom_q <= fmt_q(w_cdata, w_sel_word, w_sel_addr[0]);
                        end
                    end
                end
                ST_RD_REQ, ST_WR_REQ: begin
                    if (w_new) begin
                        r_pend   <= 1'b1;
                        r_p_addr <= bus.ROM_ADDR;
                        r_p_d    <= bus.ROM_D;
                        r_p_word <= bus.ROM_WORD;
                        r_p_wr   <= w_wr;
                    end
                    if (bus.SD_ACK) begin
                        r_state  <= ST_IDLE;
                        r_sd_req <= 1'b0;
                        if (r_state == ST_RD_REQ) begin
                            r_rom_q <= fmt_q(bus.SD_RDATA, r_cur_word, r_cur_a0);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ROM_Q    = r_rom_q;
    assign bus.BUSY     = (r_state != ST_IDLE) | r_pend;
    assign bus.SD_REQ   = r_sd_req;
    assign bus.SD_WE    = r_sd_we;
    assign bus.SD_ADDR  = r_sd_addr;
    assign bus.SD_BE    = r_sd_be;
    assign bus.SD_WDATA = r_sd_wdata;
endmodule

// File: tb/tb_rom_sdram_bridge.sv
// Scoreboard bench: stimulus queues expected SDRAM transactions and timed output
// values; independent monitors pop and compare as the DUT presents them.
module tb_rom_sdram_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rom_sdram_bridge_if #(.ADDR_W(24)) bus ();
    rom_sdram_bridge_if #(.ADDR_W(24)) bus2 ();

    rom_sdram_bridge #(.ADDR_W(24), .USE_CACHE(1'b1)) dut (
        .MCLK (clk),
        .RESET(rst),
        .bus  (bus)
    );

    rom_sdram_bridge #(.ADDR_W(24), .USE_CACHE(1'b0)) dut_nc (
        .MCLK (clk),
        .RESET(rst),
        .bus  (bus2)
    );

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] exp;
        string       name;
    } due_t;

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } sd_t;

    due_t        dueq[$];
    sd_t         sdq[$];
    logic [15:0] rdq[$];
    logic [15:0] rdq2[$];
    int          sd_pushed = 0;
    int          sd_seen = 0;
    int          nc_seen = 0;
    logic        auto_ack = 1'b1;
    logic        late_ack = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_due(input int d, input int s, input logic [31:0] e, input string nm);
        due_t t;
        t.due = d; t.sel = s; t.exp = e; t.name = nm;
        dueq.push_back(t);
    endtask

    task automatic push_sd(input logic we, input logic [23:0] a, input logic [1:0] be,
                           input logic [15:0] wd);
        sd_t t;
        t.we = we; t.addr = a; t.be = be; t.wdata = wd;
        sdq.push_back(t);
        sd_pushed++;
    endtask

    // SDRAM responders: ack 3 cycles after SD_REQ is first seen high.
    initial begin
        int cnt = 0;
        bus.SD_ACK = 1'b0;
        bus.SD_RDATA = '0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.SD_ACK) begin
                bus.SD_ACK = 1'b0;
                cnt = 0;
            end else if (late_ack) begin
                bus.SD_ACK = 1'b1;
                late_ack = 1'b0;
            end else if (bus.SD_REQ && auto_ack) begin
                if (cnt == 3) begin
                    bus.SD_ACK = 1'b1;
                    bus.SD_RDATA = (rdq.size() > 0) ? rdq.pop_front() : 16'h0000;
                end else cnt++;
            end else cnt = 0;
        end
    end

    initial begin
        int cnt = 0;
        bus2.SD_ACK = 1'b0;
        bus2.SD_RDATA = '0;
        forever begin
            @(posedge clk);
            #2;
            if (bus2.SD_ACK) begin
                bus2.SD_ACK = 1'b0;
                cnt = 0;
            end else if (bus2.SD_REQ) begin
                if (cnt == 3) begin
                    bus2.SD_ACK = 1'b1;
                    bus2.SD_RDATA = (rdq2.size() > 0) ? rdq2.pop_front() : 16'h0000;
                end else cnt++;
            end else cnt = 0;
        end
    end

    // Transaction monitors fire on each rising edge of SD_REQ.
    logic sd_prev = 1'b0;
    logic sd2_prev = 1'b0;
    always @(negedge clk) begin
        sd_t e;
        if (bus.SD_REQ && !sd_prev) begin
            sd_seen++;
            if (sdq.size() == 0) begin
                check("sd_unexpected_req", {8'h0, bus.SD_ADDR}, 32'hFFFF_FFFF);
            end else begin
                e = sdq.pop_front();
                check("sd_we", {31'h0, bus.SD_WE}, {31'h0, e.we});
                check("sd_addr", {8'h0, bus.SD_ADDR}, {8'h0, e.addr});
                check("sd_be", {30'h0, bus.SD_BE}, {30'h0, e.be});
                if (e.we) check("sd_wdata", {16'h0, bus.SD_WDATA}, {16'h0, e.wdata});
            end
        end
        sd_prev <= bus.SD_REQ;
        if (bus2.SD_REQ && !sd2_prev) begin
            nc_seen++;
            check("nc_sd_addr", {8'h0, bus2.SD_ADDR}, 32'h0000_FFFE);
        end
        sd2_prev <= bus2.SD_REQ;
    end

    // Timed output checks.
    always @(negedge clk) begin
        due_t e;
        logic [31:0] v;
        while (dueq.size() > 0 && dueq[0].due <= cyc) begin
            e = dueq.pop_front();
            case (e.sel)
                0:       v = {16'h0, bus.ROM_Q};
                1:       v = {31'h0, bus.BUSY};
                2:       v = {31'h0, bus.SD_REQ};
                3:       v = {16'h0, bus2.ROM_Q};
                default: v = {31'h0, bus2.SD_REQ};
            endcase
            check(e.name, v, e.exp);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [15:0] nc_data [3];
        nc_data[0] = 16'hBEEF; nc_data[1] = 16'h0F0F; nc_data[2] = 16'h1234;
        bus.ROM_ADDR = '0; bus.ROM_D = '0; bus.ROM_WORD = 1'b0;
        bus.ROM_CE_N = 1'b1; bus.ROM_OE_N = 1'b1; bus.ROM_WE_N = 1'b1;
        bus2.ROM_ADDR = 24'h00FFFE; bus2.ROM_D = '0; bus2.ROM_WORD = 1'b1;
        bus2.ROM_CE_N = 1'b1; bus2.ROM_OE_N = 1'b1; bus2.ROM_WE_N = 1'b1;
        tick(1);
        push_due(cyc, 0, 32'h0, "rst_rom_q");
        push_due(cyc, 1, 32'h0, "rst_busy");
        push_due(cyc, 2, 32'h0, "rst_sd_req");
        tick(1);
        rst = 1'b0;
        tick(1);

        // Word read miss.
        bus.ROM_ADDR = 24'h008000; bus.ROM_WORD = 1'b1; bus.ROM_CE_N = 1'b0; bus.ROM_OE_N = 1'b0;
        rdq.push_back(16'hA55A);
        push_sd(1'b0, 24'h008000, 2'b11, 16'h0);
        c = cyc;
        push_due(c + 1, 2, 32'h1, "miss_req");
        push_due(c + 4, 1, 32'h1, "miss_busy");
        push_due(c + 5, 0, 32'hA55A, "miss_rom_q");
        push_due(c + 5, 1, 32'h0, "miss_busy_fall");
        tick(6);

        // Byte read hit on the odd byte.
        bus.ROM_ADDR = 24'h008001; bus.ROM_WORD = 1'b0;
        c = cyc;
        push_due(c + 1, 0, 32'hA5A5, "hit_byte_rom_q");
        push_due(c + 1, 1, 32'h0, "hit_busy");
        push_due(c + 2, 2, 32'h0, "hit_no_req");
        tick(3);

        // Byte write-through to the cached word.
        bus.ROM_OE_N = 1'b1; bus.ROM_WE_N = 1'b0; bus.ROM_ADDR = 24'h008000;
        bus.ROM_D = 16'h0033; bus.ROM_WORD = 1'b0;
        push_sd(1'b1, 24'h008000, 2'b01, 16'h3333);
        c = cyc;
        push_due(c + 1, 2, 32'h1, "wr_req");
        push_due(c + 5, 1, 32'h0, "wr_busy_fall");
        tick(6);
        bus.ROM_WE_N = 1'b1; bus.ROM_OE_N = 1'b0; bus.ROM_WORD = 1'b1; bus.ROM_D = '0;
        c = cyc;
        push_due(c + 1, 0, 32'hA533, "wt_hit_word");
        push_due(c + 2, 2, 32'h0, "wt_no_req");
        tick(3);
        bus.ROM_WORD = 1'b0;
        push_due(cyc + 1, 0, 32'h3333, "wt_hit_byte_lo");
        tick(2);

        // Three accesses back to back: middle one is overwritten in the pending slot.
        bus.ROM_ADDR = 24'h000100; bus.ROM_WORD = 1'b1;
        rdq.push_back(16'h1111);
        rdq.push_back(16'h3C3C);
        push_sd(1'b0, 24'h000100, 2'b11, 16'h0);
        push_sd(1'b0, 24'h000300, 2'b11, 16'h0);
        c = cyc;
        push_due(c + 1, 2, 32'h1, "b2b_req1");
        push_due(c + 4, 1, 32'h1, "b2b_busy_inflight");
        push_due(c + 5, 0, 32'h1111, "b2b_rom_q1");
        push_due(c + 5, 1, 32'h1, "b2b_busy_pending");
        push_due(c + 5, 2, 32'h0, "b2b_req_gap");
        push_due(c + 6, 2, 32'h1, "b2b_req2");
        push_due(c + 10, 0, 32'h3C3C, "b2b_rom_q3");
        push_due(c + 10, 1, 32'h0, "b2b_busy_fall");
        tick(1);
        bus.ROM_ADDR = 24'h000200;
        tick(1);
        bus.ROM_ADDR = 24'h000300;
        tick(9);

        // Reset while a read is outstanding, then a stray ack.
        auto_ack = 1'b0;
        bus.ROM_ADDR = 24'h000500;
        push_sd(1'b0, 24'h000500, 2'b11, 16'h0);
        c = cyc;
        push_due(c + 1, 2, 32'h1, "rstmid_req");
        tick(2);
        rst = 1'b1; bus.ROM_CE_N = 1'b1; bus.ROM_OE_N = 1'b1;
        push_due(c + 2, 2, 32'h0, "rstmid_req_drop");
        push_due(c + 2, 0, 32'h0, "rstmid_rom_q");
        push_due(c + 2, 1, 32'h0, "rstmid_busy");
        tick(1);
        rst = 1'b0;
        tick(1);
        late_ack = 1'b1;
        push_due(c + 5, 2, 32'h0, "late_ack_req");
        push_due(c + 5, 1, 32'h0, "late_ack_busy");
        push_due(c + 5, 0, 32'h0, "late_ack_rom_q");
        tick(2);
        auto_ack = 1'b1;
        bus.ROM_ADDR = 24'h000300; bus.ROM_CE_N = 1'b0; bus.ROM_OE_N = 1'b0;
        rdq.push_back(16'h5AA5);
        push_sd(1'b0, 24'h000300, 2'b11, 16'h0);
        c = cyc;
        push_due(c + 1, 2, 32'h1, "post_rst_miss_req");
        push_due(c + 5, 0, 32'h5AA5, "post_rst_rom_q");
        tick(6);
        bus.ROM_CE_N = 1'b1; bus.ROM_OE_N = 1'b1;

        // Cache disabled: every read goes to SDRAM.
        for (int i = 0; i < 3; i++) begin
            bus2.ROM_CE_N = 1'b0; bus2.ROM_OE_N = 1'b0;
            rdq2.push_back(nc_data[i]);
            c = cyc;
            push_due(c + 1, 4, 32'h1, "nc_req");
            push_due(c + 5, 3, {16'h0, nc_data[i]}, "nc_rom_q");
            tick(6);
            bus2.ROM_CE_N = 1'b1; bus2.ROM_OE_N = 1'b1;
            tick(1);
        end

        tick(3);
        check("sd_txn_count", sd_seen, sd_pushed);
        check("sd_exp_left", sdq.size(), 0);
        check("due_left", dueq.size(), 0);
        check("nc_txn_count", nc_seen, 3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
